// File: rtl/mac_operand_streamer_if.sv
// Operand-side bus of mac_operand_streamer: the read port shared by the A/B
// operand memories plus the operand/clear/result lines of one mac_pe.
// Signal suffixes are seen from the streamer (_o driven by it, _i sampled).
interface mac_operand_streamer_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
);
  logic                   rd_req_o;
  logic                   rd_gnt_i;
  logic [AddrWidth-1:0]   a_addr_o;
  logic [AddrWidth-1:0]   b_addr_o;
  logic [DataWidth-1:0]   a_rdata_i;
  logic [DataWidth-1:0]   b_rdata_i;
  logic [DataWidth-1:0]   a_o;
  logic [DataWidth-1:0]   b_o;
  logic                   a_valid_o;
  logic                   b_valid_o;
  logic                   acc_clr_o;
  logic [2*DataWidth-1:0] c_i;

  // Streamer side.
  modport master (
    output rd_req_o, a_addr_o, b_addr_o, a_o, b_o, a_valid_o, b_valid_o, acc_clr_o,
    input  rd_gnt_i, a_rdata_i, b_rdata_i, c_i
  );

  // Memory / PE side.
  modport slave (
    input  rd_req_o, a_addr_o, b_addr_o, a_o, b_o, a_valid_o, b_valid_o, acc_clr_o,
    output rd_gnt_i, a_rdata_i, b_rdata_i, c_i
  );
endinterface

// File: rtl/mac_operand_streamer.sv
// Fetches K operand pairs from the A/B memories, streams them into a mac_pe,
// and captures the PE accumulator once the last pair has settled.
module mac_operand_streamer #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8,
  parameter int LenWidth  = AddrWidth + 1,
  parameter int PeLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [LenWidth-1:0]    len_i,
  input  logic [AddrWidth-1:0]   base_a_i,
  input  logic [AddrWidth-1:0]   base_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2*DataWidth-1:0] result_o,
  mac_operand_streamer_if.master bus
);

  localparam int DrainWidth = (PeLatency > 1) ? $clog2(PeLatency) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q,    state_d;
  logic [LenWidth-1:0]    len_q,      len_d;
  logic [AddrWidth-1:0]   base_a_q,   base_a_d;
  logic [AddrWidth-1:0]   base_b_q,   base_b_d;
  logic [LenWidth-1:0]    issued_q,   issued_d;
  logic [LenWidth-1:0]    received_q, received_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DrainWidth-1:0]  drain_q,    drain_d;
  logic [2*DataWidth-1:0] result_q,   result_d;

  logic rd_req;
  logic accept;
  logic beat;

  // A request is outstanding while fewer than K reads have been accepted;
  // a beat is the registered acceptance, matching the 1-cycle read latency.
  assign rd_req = (state_q == S_STREAM) && (issued_q < len_q);
  assign accept = rd_req && bus.rd_gnt_i;
  assign beat   = (state_q == S_STREAM) && rd_valid_q;

  // Next-state and datapath-register update for the command FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    issued_d   = issued_q;
    received_d = received_q;
    drain_d    = drain_q;
    result_d   = result_q;
    rd_valid_d = accept;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_d    = len_i;
            base_a_d = base_a_i;
            base_b_d = base_b_i;
            state_d  = S_CLEAR;
          end else begin
            // Empty job: report a zero result without touching PE or memories.
            result_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        issued_d   = '0;
        received_d = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          issued_d = issued_q + LenWidth'(1);
        end
        if (beat) begin
          received_d = received_q + LenWidth'(1);
          if (received_q + LenWidth'(1) == len_q) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Give the PE PeLatency cycles to fold the last beat into c_i.
        if (drain_q == DrainWidth'(PeLatency - 1)) begin
          result_d = bus.c_i;
          state_d  = S_DONE;
        end else begin
          drain_d = drain_q + DrainWidth'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; clearing rd_valid_q
  // drops any read still in flight when reset hits.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      issued_q   <= '0;
      received_q <= '0;
      rd_valid_q <= 1'b0;
      drain_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      rd_valid_q <= rd_valid_d;
      drain_q    <= drain_d;
      result_q   <= result_d;
    end
  end

  assign busy_o   = (state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

  // Addresses wrap modulo 2^AddrWidth; they read as zero while no request is up.
  assign bus.rd_req_o  = rd_req;
  assign bus.a_addr_o  = rd_req ? (base_a_q + AddrWidth'(issued_q)) : '0;
  assign bus.b_addr_o  = rd_req ? (base_b_q + AddrWidth'(issued_q)) : '0;
  assign bus.acc_clr_o = (state_q == S_CLEAR);
  assign bus.a_valid_o = beat;
  assign bus.b_valid_o = beat;
  // Operand data is meaningless without valid; gating keeps idle outputs at 0.
  assign bus.a_o       = beat ? bus.a_rdata_i : '0;
  assign bus.b_o       = beat ? bus.b_rdata_i : '0;

endmodule

// File: doc/mac_operand_streamer.md
Name: mac_operand_streamer

Overview:
- Initiator for the mac_pe operand interface.
- On a start command it fetches K operand pairs from two operand memories and streams them into the PE with a_valid/b_valid.
- It pulses acc_clr before the first pair, then captures the PE accumulator c after the last pair and reports it with a done pulse.
- It sits between the operand SRAM read ports and one mac_pe instance.

Parameters:
DataWidth, 16, operand width; PE result width is 2*DataWidth
AddrWidth, 8, operand memory address width
LenWidth, AddrWidth+1, width of the length field
PeLatency, 1, cycles from the PE's last valid beat until c_i reflects it (>=1)

Ports:
clk_i  in  1  clock; all logic rising-edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  start command; sampled only in IDLE
len_i  in  LenWidth  number of operand pairs K; sampled with start_i
base_a_i  in  AddrWidth  A base address; sampled with start_i
base_b_i  in  AddrWidth  B base address; sampled with start_i
busy_o  out  1  high in CLEAR/STREAM/DRAIN
done_o  out  1  one-cycle pulse when result_o is updated
result_o  out  2*DataWidth  captured accumulator; held until the next done_o
rd_req_o  out  1  read request to both memories
rd_gnt_i  in  1  grant; a request is accepted in any cycle with rd_req_o & rd_gnt_i
a_addr_o  out  AddrWidth  A read address
b_addr_o  out  AddrWidth  B read address
a_rdata_i  in  DataWidth  A read data, valid exactly 1 cycle after the accepted request
b_rdata_i  in  DataWidth  B read data, same timing as A
a_o  out  DataWidth  operand A to PE (a_rdata_i passed through)
b_o  out  DataWidth  operand B to PE (b_rdata_i passed through)
a_valid_o  out  1  A valid to PE
b_valid_o  out  1  B valid to PE; always equal to a_valid_o
acc_clr_o  out  1  PE accumulator clear; one-cycle pulse
c_i  in  2*DataWidth  PE accumulator output

Behaviour:
- Reset: state IDLE; all outputs 0, including result_o. Counters and the in-flight read-valid flag are cleared.
- Reset mid-operation: the next cycle is IDLE with all outputs 0. A read response arriving after reset is discarded; no valid beat is issued for it.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start_i & len_i!=0 -> CLEAR; latch len_i and both base addresses.
  - start_i & len_i==0 -> DONE with result_o cleared to 0; no acc_clr, no reads.
- CLEAR:
  - acc_clr_o=1 for exactly this cycle; valids 0.
  - issue count and receive count reset to 0 -> STREAM.
- STREAM, requests:
  - rd_req_o=1 while issued<K; a_addr_o=base_a+issued, b_addr_o=base_b+issued, both mod 2^AddrWidth (wrap).
  - issued increments only on rd_req_o & rd_gnt_i; addresses hold while the grant is low.
  - rd_gnt_i is ignored when rd_req_o=0.
- STREAM, beats:
  - a_valid_o=b_valid_o = registered (rd_req_o & rd_gnt_i), i.e. valid in the cycle after acceptance.
  - a_o=a_rdata_i and b_o=b_rdata_i combinationally. a_o/b_o are don't-care when valid is low.
  - received increments on each valid beat. The cycle presenting beat K -> DRAIN.
- DRAIN: valids 0; wait PeLatency cycles. In the last DRAIN cycle, sample c_i into result_o -> DONE.
- DONE: done_o=1 for one cycle, busy_o=0 -> IDLE. start_i is ignored in DONE.
- start_i in CLEAR/STREAM/DRAIN/DONE is ignored.
- Latency (gnt tied high, PeLatency=1, start_i in cycle 0):
  - CLEAR: cycle 1.
  - Requests: cycles 2..K+1.
  - Beats: cycles 3..K+2.
  - DRAIN: cycle K+3.
  - done_o: cycle K+4.
  - Each PeLatency cycle beyond 1 adds one cycle; each grant-low cycle adds one cycle.
- The block does no arithmetic on data; result_o is exactly c_i, full 2*DataWidth.

Test Plan:
- Basic stream. K=4, A[0..3]=1,2,3,4, B[0..3]=5,6,7,8, bases 0, gnt=1, reference PE model:
  - acc_clr_o in cycle 1; valid beats in cycles 3-6; done_o in cycle 8.
  - result_o=70 (0x46); busy_o low from cycle 8.
- Grant stall. Same data, rd_gnt_i alternating 1,0 starting high:
  - Addresses hold during gnt=0; beats in cycles 3,5,7,9.
  - Valid is never high without a preceding grant; done_o in cycle 11; result_o=70.
- Zero length. start_i with len_i=0:
  - done_o in cycle 1, result_o=0.
  - rd_req_o, acc_clr_o and valids stay 0 throughout.
- Wrap-around. base_a_i=0xFE, base_b_i=0x10, K=4:
  - a_addr_o sequence 0xFE,0xFF,0x00,0x01; b_addr_o sequence 0x10..0x13.
- Busy and reset:
  - start_i pulsed with K=2 during STREAM of a K=4 job -> ignored; the original job completes with the correct result.
  - rst_i asserted in the cycle after the 2nd beat of a K=4 job -> next cycle all outputs 0 and state IDLE.
  - No beat for the outstanding read; a fresh K=1 start (A=3, B=9) yields result_o=27.
- Back-to-back. start_i held high continuously with K=2 (A=2,3; B=4,5):
  - The first job's done_o carries result_o=23 (0x17).
  - The second job starts from the IDLE cycle after DONE (CLEAR one cycle after that), pulses acc_clr_o again and again yields 23.
